// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared definitions for the ALU arbiter slice.
// Holds the default operand width, the ALU op encodings, the arbiter FSM
// state type and a helper that classifies op codes as legal or not.
package alu_arbiter_pkg;

  localparam int unsigned XlenDefault = 32;

  // Op encodings understood by the shared ALU; 100, 110 and 111 are illegal.
  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpAnd = 3'b010,
    OpOr  = 3'b011,
    OpSlt = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  function automatic logic op_is_legal(logic [2:0] op);
    logic legal;
    case (op)
      OpAdd, OpSub, OpAnd, OpOr, OpSlt: legal = 1'b1;
      default:                          legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundle of every handshake and bus signal of the arbiter.
//   req0_* / req1_* : requester handshake, operands and op
//   alu_*           : drive to, and result from, the shared combinational ALU
//   rsp_*           : response handshake and payload
// Modports: slave (the arbiter) and master (whatever surrounds it).
interface alu_arbiter_if
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned XLEN = XlenDefault
);

  logic            req0_valid;
  logic            req0_ready;
  logic [XLEN-1:0] req0_a;
  logic [XLEN-1:0] req0_b;
  logic [2:0]      req0_op;

  logic            req1_valid;
  logic            req1_ready;
  logic [XLEN-1:0] req1_a;
  logic [XLEN-1:0] req1_b;
  logic [2:0]      req1_op;

  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [2:0]      alu_op;
  logic [XLEN-1:0] alu_res;
  logic            alu_zero;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_res;
  logic            rsp_zero;
  logic            rsp_id;
  logic            rsp_err;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  alu_res, alu_zero, rsp_ready,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_op,
    output rsp_valid, rsp_res, rsp_zero, rsp_id, rsp_err
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output alu_res, alu_zero, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_op,
    input  rsp_valid, rsp_res, rsp_zero, rsp_id, rsp_err
  );

endinterface

// File: rtl/alu_arb_rr.sv
// alu_arb_rr: two-way grant selection for the ALU arbiter (purely combinational).
//   valid0, valid1 : request valids
//   last           : requester granted by the most recent accepted transfer
//                    (absent when ALU_ARB_FIXED_PRIO_EN is defined)
//   grant          : 0 selects req0, 1 selects req1
// Build option: ALU_ARB_FIXED_PRIO_EN - req0 always wins a tie.
module alu_arb_rr
  import alu_arbiter_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
`ifndef ALU_ARB_FIXED_PRIO_EN
  input  logic last,
`endif
  output logic grant
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign grant = valid1 && !valid0;
`else
  // On a tie the requester not served last time wins; otherwise follow valid1.
  assign grant = (valid0 && valid1) ? !last : valid1;
`endif

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a single shared combinational ALU.
// One operation is in flight at a time: IDLE offers ready to the granted
// requester, EXEC drives the ALU from registered operands and captures its
// result, RESP holds the response until it is taken.
// Ports:
//   clk    - clock, all state on the rising edge
//   rst_n  - asynchronous active-low reset
//   bus_io - alu_arbiter_if.slave: request, ALU-drive and response signals
// Build option: ALU_ARB_FIXED_PRIO_EN - req0 always wins ties, no last-grant state.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned XLEN = XlenDefault
) (
  input logic          clk,
  input logic          rst_n,
  alu_arbiter_if.slave bus_io
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] alu_a_q, alu_a_d;
  logic [XLEN-1:0] alu_b_q, alu_b_d;
  logic [2:0]      alu_op_q, alu_op_d;
  logic [XLEN-1:0] rsp_res_q, rsp_res_d;
  logic            rsp_zero_q, rsp_zero_d;
  logic            rsp_id_q, rsp_id_d;
  logic            rsp_err_q, rsp_err_d;
  logic            rsp_valid_q, rsp_valid_d;

  logic            grant;
  logic            idle;
  logic            accept;
  logic [XLEN-1:0] sel_a;
  logic [XLEN-1:0] sel_b;
  logic [2:0]      sel_op;
  logic            sel_legal;

`ifdef ALU_ARB_FIXED_PRIO_EN
  alu_arb_rr u_arb (
    .valid0 (bus_io.req0_valid),
    .valid1 (bus_io.req1_valid),
    .grant  (grant)
  );
`else
  logic last_q, last_d;

  alu_arb_rr u_arb (
    .valid0 (bus_io.req0_valid),
    .valid1 (bus_io.req1_valid),
    .last   (last_q),
    .grant  (grant)
  );
`endif

  // rst_n gates ready so nothing is offered while reset is held, yet the
  // first cycle after release can already accept.
  assign idle              = rst_n && (state_q == StIdle);
  assign bus_io.req0_ready = idle && !grant;
  assign bus_io.req1_ready = idle && grant;
  assign accept            = (bus_io.req0_valid && bus_io.req0_ready) ||
                             (bus_io.req1_valid && bus_io.req1_ready);

  assign sel_a     = grant ? bus_io.req1_a  : bus_io.req0_a;
  assign sel_b     = grant ? bus_io.req1_b  : bus_io.req0_b;
  assign sel_op    = grant ? bus_io.req1_op : bus_io.req0_op;
  assign sel_legal = op_is_legal(sel_op);

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rsp_res_d   = rsp_res_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    rsp_valid_d = rsp_valid_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    last_d      = last_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d   = StExec;
          alu_a_d   = sel_a;
          alu_b_d   = sel_b;
          // An illegal op still passes through EXEC, with the ALU told to add.
          alu_op_d  = sel_legal ? sel_op : OpAdd;
          rsp_err_d = !sel_legal;
          rsp_id_d  = grant;
`ifndef ALU_ARB_FIXED_PRIO_EN
          last_d    = grant;
`endif
        end
      end
      StExec: begin
        state_d     = StResp;
        rsp_res_d   = rsp_err_q ? '0 : bus_io.alu_res;
        rsp_zero_d  = rsp_err_q ? 1'b1 : bus_io.alu_zero;
        rsp_valid_d = 1'b1;
        // The ALU is only needed for this one cycle; park its inputs at zero.
        alu_a_d     = '0;
        alu_b_d     = '0;
        alu_op_d    = OpAdd;
      end
      StResp: begin
        if (bus_io.rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = StIdle;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= OpAdd;
      rsp_res_q   <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rsp_res_q   <= rsp_res_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q      <= last_d;
`endif
    end
  end

  assign bus_io.alu_a     = alu_a_q;
  assign bus_io.alu_b     = alu_b_q;
  assign bus_io.alu_op    = alu_op_q;
  assign bus_io.rsp_valid = rsp_valid_q;
  assign bus_io.rsp_res   = rsp_res_q;
  assign bus_io.rsp_zero  = rsp_zero_q;
  assign bus_io.rsp_id    = rsp_id_q;
  assign bus_io.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random stimulus for alu_arbiter with a
// transaction-level reference model (grant rule, fixed 2-cycle latency,
// op results by plain arithmetic) and an external ALU model.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if #(.XLEN(W)) bus ();

  alu_arbiter #(.XLEN(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  // Shared ALU living outside the arbiter.
  function automatic logic [31:0] ext_alu(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b101:  return (a < b) ? 32'd1 : 32'd0;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign bus.alu_res  = ext_alu(bus.alu_op, bus.alu_a, bus.alu_b);
  assign bus.alu_zero = (bus.alu_res == 32'd0);

  // Expected response result for an op, straight from the op table.
  function automatic logic [31:0] spec_res(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b101:  return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit spec_legal(logic [2:0] op);
    return op inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b101};
  endfunction

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state: at most one transaction outstanding.
  bit          busy    = 1'b0;
  int          rsp_cyc = 0;
  int          last_g  = 1;
  logic [31:0] m_a, m_b, m_res;
  logic [2:0]  m_op_drv;
  logic        m_zero, m_err, m_id;

  // Observations recorded for the directed scenarios.
  logic [31:0] got_res;
  logic        got_zero, got_err, got_id;
  logic [2:0]  exec_op;
  int          hs_cyc   = 0;
  int          fire_cyc = 0;
  int          fire_id  = 0;
  int          acc_cyc  = 0;
  int          n_rsp    = 0;
  int          ids_q[$];
  logic [31:0] res_q[$];

`ifdef ALU_ARB_FIXED_PRIO_EN
  int          exp_ids[4] = '{0, 0, 0, 0};
  logic [31:0] exp_r4[4]  = '{32'h0, 32'h0, 32'h0, 32'h0};
`else
  int          exp_ids[4] = '{0, 1, 0, 1};
  logic [31:0] exp_r4[4]  = '{32'h0, 32'hFF, 32'h0, 32'hFF};
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(bit v0, bit v1);
`ifdef ALU_ARB_FIXED_PRIO_EN
    return (v1 && !v0) ? 1 : 0;
`else
    if (v0 && v1) return 1 - last_g;
    return v1 ? 1 : 0;
`endif
  endfunction

  // One clock cycle: drive inputs after the edge, then compare everything.
  task automatic cycle(input bit v0, input logic [2:0] op0, input logic [31:0] a0,
                       input logic [31:0] b0, input bit v1, input logic [2:0] op1,
                       input logic [31:0] a1, input logic [31:0] b1, input bit rdy);
    int gnt;
    bit f0, f1, rv;
    @(posedge clk);
    #1;
    cyc++;
    bus.req0_valid = v0; bus.req0_op = op0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_op = op1; bus.req1_a = a1; bus.req1_b = b1;
    bus.rsp_ready  = rdy;
    #1;
    if (!busy) begin
      check("idle_alu_a", bus.alu_a, 32'd0);
      check("idle_alu_b", bus.alu_b, 32'd0);
      check("idle_alu_op", 32'(bus.alu_op), 32'd0);
    end else if (cyc == rsp_cyc - 1) begin
      exec_op = bus.alu_op;
      check("exec_alu_a", bus.alu_a, m_a);
      check("exec_alu_b", bus.alu_b, m_b);
      check("exec_alu_op", 32'(bus.alu_op), 32'(m_op_drv));
    end
    rv = busy && (cyc >= rsp_cyc);
    check("rsp_valid", 32'(bus.rsp_valid), 32'(rv));
    if (rv) begin
      check("rsp_res", bus.rsp_res, m_res);
      check("rsp_zero", 32'(bus.rsp_zero), 32'(m_zero));
      check("rsp_id", 32'(bus.rsp_id), 32'(m_id));
      check("rsp_err", 32'(bus.rsp_err), 32'(m_err));
    end
    if (bus.rsp_valid && rdy) begin
      got_res = bus.rsp_res; got_zero = bus.rsp_zero;
      got_err = bus.rsp_err; got_id   = bus.rsp_id;
      hs_cyc  = cyc;
      n_rsp++;
      ids_q.push_back(int'(bus.rsp_id));
      res_q.push_back(bus.rsp_res);
    end
    if (bus.req0_valid && bus.req0_ready) begin fire_cyc = cyc; fire_id = 0; end
    if (bus.req1_valid && bus.req1_ready) begin fire_cyc = cyc; fire_id = 1; end
    gnt = pick(v0, v1);
    f0  = !busy && v0 && (gnt == 0);
    f1  = !busy && v1 && (gnt == 1);
    check("fire0", 32'(bus.req0_valid && bus.req0_ready), 32'(f0));
    check("fire1", 32'(bus.req1_valid && bus.req1_ready), 32'(f1));
    if (rv && rdy) busy = 1'b0;
    if (f0 || f1) begin
      busy     = 1'b1;
      rsp_cyc  = cyc + 2;
      acc_cyc  = cyc;
      last_g   = gnt;
      m_id     = (gnt == 1);
      m_a      = f1 ? a1 : a0;
      m_b      = f1 ? b1 : b0;
      m_err    = !spec_legal(f1 ? op1 : op0);
      m_op_drv = m_err ? 3'b000 : (f1 ? op1 : op0);
      m_res    = m_err ? 32'd0 : spec_res(f1 ? op1 : op0, m_a, m_b);
      m_zero   = (m_res == 32'd0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, OpAdd, 32'd0, 32'd0, 1'b0, OpAdd, 32'd0, 32'd0, 1'b1);
  endtask

  // Reset asserted mid-cycle with both valids high; released on the next negedge.
  task automatic pulse_reset();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst_ready0", 32'(bus.req0_ready), 32'd0);
    check("rst_ready1", 32'(bus.req1_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_alu_a", bus.alu_a, 32'd0);
    check("rst_alu_b", bus.alu_b, 32'd0);
    check("rst_alu_op", 32'(bus.alu_op), 32'd0);
    check("rst_rsp_res", bus.rsp_res, 32'd0);
    check("rst_rsp_zero", 32'(bus.rsp_zero), 32'd0);
    check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    busy   = 1'b0;
    last_g = 1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rnd_opnd();
    if ($urandom_range(0, 1) != 0) return 32'($urandom_range(0, 3));
    return $urandom;
  endfunction

  initial begin
    int n_before;
    bus.req0_valid = 1'b0; bus.req0_op = 3'b000; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_op = 3'b000; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready  = 1'b0;
    #2;
    pulse_reset();

    // Both requesters valid every cycle: ids alternate, 3 cycles per op.
    ids_q.delete();
    res_q.delete();
    repeat (12) cycle(1'b1, OpSub, 32'd3, 32'd3, 1'b1, OpOr, 32'hF0, 32'h0F, 1'b1);
    idle(3);
    check("alt_count", 32'(ids_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < ids_q.size()) begin
        check("alt_id", 32'(ids_q[i]), 32'(exp_ids[i]));
        check("alt_res", res_q[i], exp_r4[i]);
      end
    end

    // Single req0 add: response two cycles after accept.
    cycle(1'b1, OpAdd, 32'd5, 32'd7, 1'b0, OpAdd, 32'd0, 32'd0, 1'b1);
    idle(2);
    check("add_res", got_res, 32'd12);
    check("add_zero", 32'(got_zero), 32'd0);
    check("add_id", 32'(got_id), 32'd0);
    check("add_latency", 32'(hs_cyc - acc_cyc), 32'd2);

    // Unsigned set-less-than.
    cycle(1'b1, OpSlt, 32'd2, 32'd9, 1'b0, OpAdd, 32'd0, 32'd0, 1'b1);
    idle(2);
    check("slt_res", got_res, 32'd1);

    // Illegal op from req1.
    cycle(1'b0, OpAdd, 32'd0, 32'd0, 1'b1, 3'b111, 32'd9, 32'd4, 1'b1);
    idle(2);
    check("ill_err", 32'(got_err), 32'd1);
    check("ill_res", got_res, 32'd0);
    check("ill_zero", 32'(got_zero), 32'd1);
    check("ill_id", 32'(got_id), 32'd1);
    check("ill_alu_op", 32'(exec_op), 32'd0);

    // Response back-pressure: 5 stalled RESP cycles with requests pending.
    cycle(1'b1, OpAnd, 32'hFF, 32'h0F, 1'b0, OpAdd, 32'd0, 32'd0, 1'b0);
    repeat (6) cycle(1'b1, OpOr, 32'd1, 32'd2, 1'b1, OpAdd, 32'd3, 32'd4, 1'b0);
    cycle(1'b1, OpOr, 32'd1, 32'd2, 1'b1, OpAdd, 32'd3, 32'd4, 1'b1);
    check("bp_res", got_res, 32'h0F);
    cycle(1'b1, OpOr, 32'd1, 32'd2, 1'b1, OpAdd, 32'd3, 32'd4, 1'b1);
    check("bp_resume", 32'(fire_cyc - hs_cyc), 32'd1);
    idle(3);

    // Reset during EXEC discards the op and restores the req0 tie preference.
    cycle(1'b1, OpAdd, 32'd1, 32'd2, 1'b0, OpAdd, 32'd0, 32'd0, 1'b1);
    cycle(1'b0, OpAdd, 32'd0, 32'd0, 1'b0, OpAdd, 32'd0, 32'd0, 1'b1);
    pulse_reset();
    n_before = n_rsp;
    idle(4);
    check("rst_no_rsp", 32'(n_rsp - n_before), 32'd0);
    cycle(1'b1, OpSub, 32'd9, 32'd2, 1'b1, OpAdd, 32'd1, 32'd1, 1'b1);
    check("rst_tie_id", 32'(fire_id), 32'd0);
    idle(3);

    // Random traffic against the model.
    repeat (400) begin
      cycle($urandom_range(0, 9) < 6, 3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(),
            $urandom_range(0, 9) < 6, 3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(),
            $urandom_range(0, 9) < 7);
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
